// File: rtl/fact_engine.sv
// Iterative factorial engine: n! computed as a chain of LSB-first shift-add
// multiplications, one multiplier bit per cycle, with a sticky overflow flag.
module fact_engine #(
   parameter int N_W = 8,
   parameter int R_W = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           op_start,
   input  logic [N_W-1:0] op_n,
   output logic           op_busy,
   output logic           op_done,
   output logic [R_W-1:0] op_result,
   output logic           op_ovf
);

   localparam int P_W = R_W + N_W;
   localparam int C_W = (N_W > 1) ? $clog2(N_W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [N_W-1:0] k_q, k_d;
   logic [N_W-1:0] k_shift_q, k_shift_d;
   logic [P_W-1:0] acc_shift_q, acc_shift_d;
   logic [P_W-1:0] psum_q, psum_d;
   logic [C_W-1:0] bit_cnt_q, bit_cnt_d;
   logic           ovf_sticky_q, ovf_sticky_d;
   logic [R_W-1:0] result_q, result_d;
   logic           ovf_q, ovf_d;

   logic [P_W-1:0] psum_add;
   logic [N_W-1:0] k_dec;
   logic           ovf_step;

   // The running product "acc" lives only as the reload value of acc_shift:
   // at the end of each factor step the truncated psum goes straight back in.
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      k_shift_d    = k_shift_q;
      acc_shift_d  = acc_shift_q;
      psum_d       = psum_q;
      bit_cnt_d    = bit_cnt_q;
      ovf_sticky_d = ovf_sticky_q;
      result_d     = result_q;
      ovf_d        = ovf_q;

      psum_add = psum_q + (k_shift_q[0] ? acc_shift_q : '0);
      k_dec    = k_q - N_W'(1);
      ovf_step = ovf_sticky_q | (|psum_add[P_W-1:R_W]);

      case (state_q)
         S_IDLE: begin
            if (op_start) begin
               k_d          = op_n;
               k_shift_d    = op_n;
               acc_shift_d  = P_W'(1);
               psum_d       = '0;
               bit_cnt_d    = '0;
               ovf_sticky_d = 1'b0;
               if (op_n <= N_W'(1)) begin
                  state_d  = S_DONE;
                  result_d = R_W'(1);
                  ovf_d    = 1'b0;
               end else begin
                  state_d = S_MUL;
               end
            end
         end

         S_MUL: begin
            if (bit_cnt_q == C_W'(N_W - 1)) begin
               ovf_sticky_d = ovf_step;
               k_d          = k_dec;
               if (k_dec == N_W'(1)) begin
                  state_d  = S_DONE;
                  result_d = psum_add[R_W-1:0];
                  ovf_d    = ovf_step;
               end else begin
                  acc_shift_d = P_W'(psum_add[R_W-1:0]);
                  k_shift_d   = k_dec;
                  psum_d      = '0;
                  bit_cnt_d   = '0;
               end
            end else begin
               psum_d      = psum_add;
               acc_shift_d = acc_shift_q << 1;
               k_shift_d   = k_shift_q >> 1;
               bit_cnt_d   = bit_cnt_q + C_W'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         k_shift_q    <= '0;
         acc_shift_q  <= '0;
         psum_q       <= '0;
         bit_cnt_q    <= '0;
         ovf_sticky_q <= 1'b0;
         result_q     <= '0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         k_shift_q    <= k_shift_d;
         acc_shift_q  <= acc_shift_d;
         psum_q       <= psum_d;
         bit_cnt_q    <= bit_cnt_d;
         ovf_sticky_q <= ovf_sticky_d;
         result_q     <= result_d;
         ovf_q        <= ovf_d;
      end
   end

   assign op_busy   = (state_q == S_MUL);
   assign op_done   = (state_q == S_DONE);
   assign op_result = result_q;
   assign op_ovf    = ovf_q;

endmodule

// File: tb/tb_fact_engine.sv
// Directed bench for fact_engine: hand-computed factorials, latencies,
// overflow behaviour, mid-operation reset and ignored starts.
module tb_fact_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_start;
   logic [7:0]  op_n;
   logic        op_busy;
   logic        op_done;
   logic [63:0] op_result;
   logic        op_ovf;

   int compared   = 0;
   int mismatched = 0;

   fact_engine #(.N_W(8), .R_W(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_start  (op_start),
      .op_n      (op_n),
      .op_busy   (op_busy),
      .op_done   (op_done),
      .op_result (op_result),
      .op_ovf    (op_ovf)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Start an operation in cycle 0 and watch until a few cycles past the
   // expected done cycle, checking busy window, done timing and the result.
   task automatic applyStimulus(input string tag, input logic [7:0] n, input logic [63:0] expRes,
                                input logic expOvf, input int expDone);
      int doneCnt   = 0;
      int firstDone = -1;
      int busyBad   = 0;
      logic [63:0] resAtDone = '0;
      logic        ovfAtDone = 1'b0;
      op_n     = n;
      op_start = 1'b1;
      tick();
      op_start = 1'b0;
      op_n     = 8'hA5;
      for (int cyc = 1; cyc <= expDone + 3; cyc++) begin
         if (op_busy !== (cyc < expDone)) busyBad++;
         if (op_done === 1'b1) begin
            doneCnt++;
            if (firstDone < 0) begin
               firstDone = cyc;
               resAtDone = op_result;
               ovfAtDone = op_ovf;
            end
         end
         tick();
      end
      checkOutput({tag, " done_cycle"}, 64'(firstDone), 64'(expDone));
      checkOutput({tag, " done_count"}, 64'(doneCnt), 64'd1);
      checkOutput({tag, " busy_errs"}, 64'(busyBad), 64'd0);
      checkOutput({tag, " result"}, resAtDone, expRes);
      checkOutput({tag, " ovf"}, 64'(ovfAtDone), 64'(expOvf));
      checkOutput({tag, " result_held"}, op_result, expRes);
   endtask

   initial begin
      int doneCnt;
      logic [63:0] resAtDone;
      int firstDone;

      reset    = 1'b1;
      op_start = 1'b0;
      op_n     = '0;
      tick();
      tick();
      reset = 1'b0;
      checkOutput("reset busy", 64'(op_busy), 64'd0);
      checkOutput("reset done", 64'(op_done), 64'd0);
      checkOutput("reset result", op_result, 64'd0);
      checkOutput("reset ovf", 64'(op_ovf), 64'd0);

      applyStimulus("n5", 8'd5, 64'd120, 1'b0, 33);
      applyStimulus("n0", 8'd0, 64'd1, 1'b0, 1);
      applyStimulus("n1", 8'd1, 64'd1, 1'b0, 1);
      applyStimulus("n20", 8'd20, 64'd2432902008176640000, 1'b0, 153);
      applyStimulus("n21", 8'd21, 64'd14197454024290336768, 1'b1, 161);
      applyStimulus("n3", 8'd3, 64'd6, 1'b0, 17);

      // Reset in cycle 20 of an n=6 operation must abandon it silently.
      doneCnt  = 0;
      op_n     = 8'd6;
      op_start = 1'b1;
      tick();
      op_start = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (op_done === 1'b1) doneCnt++;
         if (cyc == 20) reset = 1'b1;
         tick();
      end
      reset = 1'b0;
      checkOutput("midrst busy", 64'(op_busy), 64'd0);
      checkOutput("midrst done", 64'(op_done), 64'd0);
      checkOutput("midrst result", op_result, 64'd0);
      checkOutput("midrst ovf", 64'(op_ovf), 64'd0);
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (op_done === 1'b1) doneCnt++;
         tick();
      end
      checkOutput("midrst no_done", 64'(doneCnt), 64'd0);
      applyStimulus("n4 after rst", 8'd4, 64'd24, 1'b0, 25);

      // Starts during MUL and DONE are ignored; one held into IDLE is taken.
      doneCnt   = 0;
      firstDone = -1;
      resAtDone = '0;
      op_n      = 8'd4;
      op_start  = 1'b1;
      tick();
      for (int cyc = 1; cyc <= 100; cyc++) begin
         if (op_done === 1'b1) begin
            doneCnt++;
            if (cyc == 25) resAtDone = op_result;
            if (cyc > 25 && firstDone < 0) firstDone = cyc;
         end
         if (cyc == 26) checkOutput("ovl single_done", 64'(doneCnt), 64'd1);
         op_start = (cyc == 5 || cyc == 25 || cyc == 26);
         op_n     = op_start ? 8'd9 : 8'd0;
         tick();
      end
      op_start = 1'b0;
      checkOutput("ovl first_result", resAtDone, 64'd24);
      checkOutput("ovl second_done_cycle", 64'(firstDone), 64'd91);
      checkOutput("ovl total_done", 64'(doneCnt), 64'd2);
      checkOutput("ovl n9 result", op_result, 64'd362880);
      checkOutput("ovl n9 ovf", 64'(op_ovf), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
